// File: rtl/ifetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ifetch_ctrl: single-outstanding instruction fetch over a req/ack bus  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic [31:0] ibus_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic        InstrValidF,
   output logic        FetchStall,
   output logic        BusErr
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] HOLD  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

   logic [2:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pcf_q, pcf_d;
   logic [31:0]      pend_q, pend_d;
   logic             valid_q, valid_d;
   logic             berr_q, berr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] tgt_aligned;
   logic        req;
   logic        tmo_hit;

   assign tgt_aligned = PCTargetE & ~32'h3;
   assign req         = (state_q == WAIT) || (state_q == DRAIN);
   assign tmo_hit     = TMO_EN && !ibus_ack && (cnt_q >= TMO_LIMIT);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pcf_d   = pcf_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      berr_d  = berr_q;
      cnt_d   = cnt_q;

      if (req) begin
         cnt_d = ibus_ack ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            state_d = WAIT;
            cnt_d   = '0;
            if (PCSrcE) begin
               addr_d = tgt_aligned;
            end
         end
         WAIT: begin
            if (ibus_ack) begin
               if (PCSrcE) begin
                  addr_d = tgt_aligned;
               end else begin
                  instr_d = ibus_rdata;
                  pcf_d   = addr_q;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end else if (tmo_hit) begin
               state_d = ERR;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               berr_d  = 1'b1;
            end else if (PCSrcE) begin
               // Request must stay stable until acked; remember where to go.
               pend_d  = tgt_aligned;
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            if (ibus_ack) begin
               addr_d  = PCSrcE ? tgt_aligned : pend_q;
               state_d = WAIT;
               cnt_d   = '0;
            end else if (tmo_hit) begin
               state_d = ERR;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               berr_d  = 1'b1;
            end else if (PCSrcE) begin
               pend_d = tgt_aligned;
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               addr_d  = tgt_aligned;
               state_d = WAIT;
               cnt_d   = '0;
            end else if (!StallD) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               addr_d  = pcf_q + 32'd4;
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcf_q   <= 32'h0;
         pend_q  <= 32'h0;
         valid_q <= 1'b0;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         pcf_q   <= pcf_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         berr_q  <= berr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ibus_req    = req;
   assign ibus_addr   = addr_q;
   assign InstrF      = instr_q;
   assign PCF         = pcf_q;
   assign InstrValidF = valid_q;
   assign FetchStall  = !valid_q;
   assign BusErr      = berr_q;

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Sequences instruction fetch for the RV32I pipeline front end over a variable-latency req/ack instruction bus. This replaces the single-cycle ROM path for slow or shared instruction memory.
- Owns the fetch address. Issues one request at a time, captures the returned word, and holds it until decode consumes it.
- Kills in-flight or buffered fetches on an execute-stage redirect.
- Drives FetchStall to the hazard unit, which ORs it into StallF/StallD.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- TIMEOUT_CYCLES, 255, cycles without ack before bus error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must fit in CNT_W bits.
- NOP_INSTR, 32'h00000013, value driven on InstrF when no valid instruction is held (addi x0,x0,0).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- PCSrcE  in  1  redirect from execute (taken branch or jump).
- PCTargetE  in  32  redirect target.
- StallD  in  1  decode not accepting this cycle.
- ibus_req  out  1  request valid; held until ack.
- ibus_addr  out  32  word address of request; bits [1:0] always 0; stable while ibus_req=1.
- ibus_ack  in  1  response valid this cycle; completes the request.
- ibus_rdata  in  32  instruction word, sampled when ibus_ack=1.
- InstrF  out  32  fetched instruction (registered).
- PCF  out  32  address of InstrF (registered).
- InstrValidF  out  1  InstrF/PCF hold a live instruction.
- FetchStall  out  1  combinational, equals !InstrValidF.
- BusErr  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any state):
  - state=IDLE, ibus_req=0, ibus_addr=RESET_PC.
  - InstrF=NOP_INSTR, PCF=0, InstrValidF=0, BusErr=0, counter=0.
  - Any outstanding bus transaction is abandoned.
- States: IDLE, WAIT, HOLD, DRAIN, ERR.
- ibus_req is 1 in WAIT and DRAIN, 0 otherwise.
- Consume = InstrValidF & !StallD & !PCSrcE. A redirect has priority over consume and over ack.
- IDLE:
  - Next edge goes to WAIT with ibus_addr = PCSrcE ? PCTargetE : ibus_addr (RESET_PC after reset).
- WAIT:
  - ack & !PCSrcE:
    - InstrF<=ibus_rdata, PCF<=ibus_addr, InstrValidF<=1.
    - Go to HOLD. InstrValidF rises the cycle after ack.
  - ack & PCSrcE: discard rdata; ibus_addr<=PCTargetE; stay in WAIT.
  - !ack & PCSrcE: latch PCTargetE into pending target; go to DRAIN. ibus_addr is unchanged, per the bus stability rule.
  - !ack & !PCSrcE: stay; counter increments.
- DRAIN:
  - PCSrcE: pending target <= PCTargetE (the newest redirect wins).
  - ack: discard rdata; ibus_addr <= pending target, or PCTargetE if PCSrcE is asserted the same cycle; go to WAIT.
- HOLD:
  - Consume: InstrValidF<=0, InstrF<=NOP_INSTR, ibus_addr<=PCF+4 (mod 2^32, wraps to 0), go to WAIT. The next request is asserted the cycle after consume.
  - PCSrcE: InstrValidF<=0, InstrF<=NOP_INSTR, ibus_addr<=PCTargetE, go to WAIT.
  - Else (StallD): hold all outputs unchanged.
- Throughput: with zero-wait ack, one instruction per 2 cycles.
- Alignment: any address loaded from PCTargetE has bits [1:0] forced to 0.
- Timeout:
  - Counter clears on entry to WAIT or DRAIN and on ack.
  - Increments each cycle ibus_req=1 & !ibus_ack.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no ack, next edge enters ERR.
- ERR:
  - ibus_req=0, InstrValidF=0, InstrF=NOP_INSTR, BusErr=1.
  - Ignores all inputs; exits only by RST.
- Invariant: at most one outstanding request. A late ack arriving while in IDLE, HOLD or ERR is ignored.

Test Plan:
- Reset then zero-wait bus (ack in every req cycle, rdata=0x00500093):
  - req at cycle 1 with addr 0x0; InstrValidF=1, InstrF=0x00500093, PCF=0x0 at cycle 2.
  - With StallD=0, next req at cycle 3 with addr 0x4.
- StallD=1 for 5 cycles while in HOLD:
  - InstrF/PCF held; ibus_req=0 throughout.
  - Release StallD: next req issued with addr PCF+4.
- Bus with 3-cycle ack latency, PCSrcE=1 with PCTargetE=0x100 in the first wait cycle:
  - ibus_addr stays at the old address until ack; that rdata is discarded (InstrValidF stays 0).
  - Next req is at 0x100.
- PCSrcE=1 with PCTargetE=0x203 in HOLD with StallD=1:
  - InstrValidF=0 next cycle; req at addr 0x200.
- PCF=0xFFFFFFFC consumed: next req at 0x00000000.
- TIMEOUT_CYCLES=4, ack never asserted:
  - ERR entered 5 cycles after req rises; BusErr=1, ibus_req=0.
  - Stays in ERR despite PCSrcE; RST asserted mid-cycle clears all outputs immediately.
